godai_data_mem_responder: RTL and testbench
===========================================

Name: godai_data_mem_responder

Overview:
- Memory-side responder for the core's data memory interface (req/gnt/rvalid protocol). It is the slave the core's data port talks to.
- Grants requests, performs byte-enabled word writes and word reads on an internal RAM, and returns in-order responses after a fixed latency.
- Sits beside the godai_wrapper instance in the Godai top level, and is also the data-memory model used by the core-level benches.

Parameters:
- ADDR_WIDTH, 32, width of data_addr_i.
- DATA_WIDTH, 32, data word width; fixed at 32, be is 4 bits.
- DEPTH, 1024, number of 32-bit words in the RAM; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.
- LATENCY, 1, cycles from the grant edge to rvalid; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_req_i  in  1  request from the core; held until granted.
- data_gnt_o  out  1  grant; combinational from data_req_i and the stall state.
- data_rvalid_o  out  1  response valid, exactly one cycle per granted request.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; bit n selects wdata[8n+7:8n].
- data_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rdata_o  out  DATA_WIDTH  read data; qualified by rvalid.
- data_err_o  out  1  error flag; qualified by rvalid.

Behaviour:
- Reset values: data_gnt_o=0 while data_req_i=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0. The delay line is cleared.
- The RAM contents are not reset.
- A reset during operation drops all in-flight responses; no rvalid is produced for them.
- Grant: data_gnt_o = data_req_i & ~stall. In this configuration stall=0 unless the optional feature below is compiled in. A handshake occurs when req & gnt are both high at a rising edge.
- Address decode: word index = (data_addr_i - BASE_ADDR) >> 2. The access is in range iff data_addr_i >= BASE_ADDR and word index < DEPTH. The subtraction is done at ADDR_WIDTH bits and must not wrap, so addresses below BASE_ADDR are out of range.
- Write handshake, in range: update only the enabled bytes at the handshake edge. be=4'b0000 is legal and writes nothing. Response is err=0, rdata=0.
- Read handshake, in range: sample the RAM word at the handshake edge. Response is err=0, rdata=word.
- A read granted the cycle after a write to the same word returns the new data.
- Any out-of-range handshake: no RAM change; response is err=1, rdata=32'h0.
- Response timing: LATENCY-stage delay line. A handshake at edge N makes rvalid=1 for exactly the cycle after edge N+LATENCY-1.
- With LATENCY=1, rvalid is high in the cycle directly after the handshake.
- Back-to-back handshakes (one per cycle) give back-to-back rvalids, in order. There is no back-pressure on responses and no full condition, because at most one entry enters per cycle.
- rdata_o and err_o are held at 0 whenever rvalid=0.
- Writes also produce rvalid, as the core requires.

Optional Feature:
- Macro: GODAI_DMEM_GNT_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle and is set to the seed on reset. stall = (lfsr[1:0]==2'b00). Grant is withheld in any stall cycle; a pending request stays pending and is granted in a later non-stall cycle.
- Not defined: the LFSR is absent, stall is tied to 0, and every request is granted in its first cycle.

Decomposition:
- Package godai_mem_pkg holds:
  - LATENCY_MAX=8, LFSR_SEED=16'hACE1, LFSR tap constants.
  - typedef struct packed {logic valid; logic err; logic [31:0] rdata;} dmem_resp_t.
- One sub-module, godai_resp_delay_line: a parameterised LATENCY-deep shift register of dmem_resp_t with synchronous clear on rst. The top level holds the RAM, the address decode, and the grant/LFSR logic.

Test Plan:
- Reset: hold rst 3 cycles with req=1 -> rvalid=0 throughout. After release, gnt=1 in the same cycle (stall macro off).
- LATENCY=1: write addr 0x10, be=4'hF, wdata 0xDEADBEEF, then read 0x10 -> read rvalid one cycle after its grant, rdata=0xDEADBEEF, err=0.
- Byte enables: write 0x11223344 to 0x20 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read -> rdata=0x11BB33DD.
- Out of range with DEPTH=1024, BASE=0: read 0x1000 -> err=1, rdata=0. Write 0x1000, then read 0xFFC -> 0xFFC unchanged.
- LATENCY=4: 5 back-to-back reads of 0x0..0x10 -> 5 consecutive rvalids starting 4 cycles after the first grant, in order. Assert rst mid-stream -> no rvalid after the reset edge.
- GODAI_DMEM_GNT_STALL_EN: 1000 random requests against a scoreboard -> every request eventually granted, rvalid count equals grant count, all data matches, and at least one stall cycle is observed.

Source files
------------

// File: rtl/godai_mem_pkg.sv
// godai_mem_pkg
// Shared types and constants for the Godai data-memory responder.
//   LATENCY_MAX  : deepest supported response delay line
//   LFSR_SEED    : reset value of the grant-stall LFSR
//   LFSR_TAPS    : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   dmem_resp_t  : one response slot travelling down the delay line
package godai_mem_pkg;

  localparam int          LATENCY_MAX = 8;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dmem_resp_t;

endpackage

// File: rtl/godai_resp_delay_line.sv
// godai_resp_delay_line
// LATENCY-deep shift register of responses; synchronous clear on rst.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high clear of every stage
//   resp_i  in   response entering stage 0 (valid=0 when idle)
//   resp_o  out  response leaving the last stage
module godai_resp_delay_line
  import godai_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  dmem_resp_t resp_i,
  output dmem_resp_t resp_o
);

  dmem_resp_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= resp_i;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign resp_o = stage[LATENCY-1];

endmodule

// File: rtl/godai_data_mem_responder.sv
// godai_data_mem_responder
// Data-memory slave for the core's req/gnt/rvalid port: byte-enabled word
// writes and word reads on an internal RAM, in-order responses after a fixed
// LATENCY (1..8). Out-of-range accesses respond with err=1, rdata=0.
// Optional macro GODAI_DMEM_GNT_STALL_EN: a 16-bit LFSR withholds grant in
// cycles where lfsr[1:0]==0; otherwise every request is granted at once.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   data_req_i     request, held until granted
//   data_gnt_o     grant (combinational)
//   data_rvalid_o  one-cycle response strobe per granted request
//   data_we_i      1 = write, 0 = read
//   data_be_i      byte enables
//   data_addr_i    byte address (bits [1:0] ignored)
//   data_wdata_i   write data
//   data_rdata_o   read data, 0 unless rvalid
//   data_err_o     error flag, 0 unless rvalid
module godai_data_mem_responder
  import godai_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                  stall;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           mem [DEPTH];
  dmem_resp_t            resp_in;
  dmem_resp_t            resp_out;

`ifdef GODAI_DMEM_GNT_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign data_gnt_o = data_req_i & ~stall;
  assign hs         = data_req_i & data_gnt_o;

  // The explicit >= guard keeps addresses below BASE_ADDR from wrapping
  // into a valid index.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) &&
                    ((offset >> 2) < ADDR_WIDTH'(DEPTH));
  assign idx      = offset[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst && hs && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Read data is captured at the handshake edge, so a read right after a
  // write to the same word already sees the updated RAM.
  always_comb begin
    resp_in = '0;
    if (hs) begin
      resp_in.valid = 1'b1;
      if (!in_range)       resp_in.err   = 1'b1;
      else if (!data_we_i) resp_in.rdata = mem[idx];
    end
  end

  godai_resp_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign data_rvalid_o = resp_out.valid;
  assign data_rdata_o  = resp_out.valid ? resp_out.rdata : '0;
  assign data_err_o    = resp_out.valid & resp_out.err;

endmodule

// File: tb/tb_godai_data_mem_responder.sv
// Bench for godai_data_mem_responder: two instances (LATENCY 1 and 4) share
// the same stimulus; a scoreboard per instance holds expected responses
// tagged with the edge after which they must appear.
module tb_godai_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt1, rv1, er1, gnt4, rv4, er4;
  logic [31:0] rd1, rd4;

  always #5 clk = ~clk;

  godai_data_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .data_req_i(req), .data_gnt_o(gnt1),
    .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rd1), .data_err_o(er1));

  godai_data_mem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .data_req_i(req), .data_gnt_o(gnt4),
    .data_rvalid_o(rv4), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rd4), .data_err_o(er4));

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  exp_t        q1[$], q4[$];
  logic [31:0] mdl [1024];
  int          e = 0;
  int          checks = 0, errors = 0;
  int          hs_cnt = 0, rv_cnt = 0, stall_cnt = 0;
  bit          stall_m = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) e <= e + 1;

  task automatic chk(input int lat, input logic v, input logic er,
                     input logic [31:0] d, input bit have, input exp_t x);
    logic        wv, we_;
    logic [31:0] wd;
    wv  = have;
    we_ = have ? x.err : 1'b0;
    wd  = have ? x.rd : 32'h0;
    checks++;
    if ({v, er, d} !== {wv, we_, wd}) begin
      errors++;
      $display("FAIL resp_lat%0d edge %0d: got v=%b err=%b d=%h, want v=%b err=%b d=%h",
               lat, e, v, er, d, wv, we_, wd);
    end
  endtask

  task automatic tick();
    bit   h1, h4;
    exp_t x1, x4;
    @(negedge clk);
    if (rst) begin
      q1.delete();
      q4.delete();
    end
`ifdef GODAI_DMEM_GNT_STALL_EN
    if (rst) m_lfsr = 16'hACE1;
    else     m_lfsr = {m_lfsr[14:0], m_lfsr[15]^m_lfsr[13]^m_lfsr[12]^m_lfsr[10]};
    stall_m = (m_lfsr[1:0] == 2'b00);
`endif
    h1 = (q1.size() > 0) && (q1[0].due == e);
    h4 = (q4.size() > 0) && (q4[0].due == e);
    x1 = '{0, 1'b0, 32'h0};
    x4 = '{0, 1'b0, 32'h0};
    if (h1) x1 = q1.pop_front();
    if (h4) x4 = q4.pop_front();
    if (rv1 === 1'b1) rv_cnt++;
    chk(1, rv1, er1, rd1, h1, x1);
    chk(4, rv4, er4, rd4, h4, x4);
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit use_tab, input logic t_err,
                       input logic [31:0] t_rd, output bit hs);
    exp_t x;
    logic exp_g, inr;
    req = r; we = w; be = b; addr = a; wdata = d;
    #1;
    exp_g = r & ~stall_m;
    if (e > 0) begin
      checks++;
      if (gnt1 !== exp_g || gnt4 !== exp_g) begin
        errors++;
        $display("FAIL gnt edge %0d: got %b/%b, want %b", e, gnt1, gnt4, exp_g);
      end
      if (r && stall_m) stall_cnt++;
    end
    hs = exp_g && !rst;
    if (hs) begin
      inr   = (a < 32'h1000);
      x.err = !inr;
      x.rd  = (inr && !w) ? mdl[a[11:2]] : 32'h0;
      if (use_tab) begin
        x.err = t_err;
        x.rd  = t_rd;
      end
      if (inr && w)
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[a[11:2]][8*i +: 8] = d[8*i +: 8];
      x.due = e + 1; q1.push_back(x);
      x.due = e + 4; q4.push_back(x);
      hs_cnt++;
    end
  endtask

  task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input bit use_tab,
                      input logic t_err, input logic [31:0] t_rd);
    bit hs;
    int n = 0;
    do begin
      drive(1'b1, w, b, a, d, use_tab, t_err, t_rd, hs);
      tick();
      n++;
    end while (!hs && n < 32);
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL no_grant addr %h: got 0 grants in %0d cycles, want 1", a, n);
    end
  endtask

  task automatic idle(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
      tick();
    end
  endtask

  vec_t vecs [13];

  initial begin
    bit hs;
    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h20,       32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h20,       32'hAABBCCDD, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h20,       32'h0,        1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b0, 4'hF, 32'h1000,     32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 32'hFFC,      32'h01020304, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, 32'h1000,     32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'hFFC,      32'h0,        1'b0, 32'h01020304};
    vecs[9]  = '{1'b1, 4'h0, 32'h20,       32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h20,       32'h0,        1'b0, 32'h11BB33DD};
    vecs[11] = '{1'b0, 4'hF, 32'h22,       32'h0,        1'b0, 32'h11BB33DD};
    vecs[12] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};

    // reset held 3 cycles with a pending read: no responses
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
      tick();
    end
    rst = 1'b0;

    // table-driven back-to-back vectors
    for (int i = 0; i < 13; i++)
      xfer(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 1'b1,
           vecs[i].e_err, vecs[i].e_rd);
    idle(5);

    // preload words 0..63 with known data
    for (int i = 0; i < 64; i++)
      xfer(1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0);
    idle(5);

    // 5 back-to-back reads 0x0..0x10, drain
    for (int i = 0; i < 5; i++)
      xfer(1'b0, 4'hF, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);
    idle(6);

    // reset mid-stream: in-flight responses are dropped
    for (int i = 0; i < 3; i++)
      xfer(1'b0, 4'hF, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6);

    // random traffic
    hs_cnt = 0;
    rv_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      if ($urandom_range(3) == 0) idle(1);
      if ($urandom_range(15) == 0) a = 32'h1000 + ($urandom_range(255) << 2);
      else                         a = ($urandom_range(63) << 2) | $urandom_range(3);
      xfer(1'($urandom_range(1)), 4'($urandom), a, $urandom, 1'b0, 1'b0, 32'h0);
    end
    idle(6);
    checks++;
    if (rv_cnt != hs_cnt) begin
      errors++;
      $display("FAIL rvalid_count: got %0d, want %0d", rv_cnt, hs_cnt);
    end
`ifdef GODAI_DMEM_GNT_STALL_EN
    checks++;
    if (stall_cnt == 0) begin
      errors++;
      $display("FAIL stall_seen: got %0d stall cycles, want >0", stall_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
